// File: rtl/iref_pwr_seq.sv
// ---------------------------------------------------------------------------
// iref_pwr_seq
//   Power-up / calibration sequencer for the current reference and one
//   downstream analog consumer gated on it.
//   OFF -> SETTLE -> CAL -> BLK -> ACTIVE. A timeout or a loss of ready sends
//   the sequencer to a sticky FAULT. Dropping EN powers down in order:
//   consumer first, then the reference one cycle later.
//
//   Optional feature macro: IREF_PWR_SEQ_RETRY_EN
//     Defined   : a CAL/BLK timeout retries the sequence (via PWRDN/OFF) up to
//                 MAX_RETRY times before FAULT.
//     Undefined : any timeout goes straight to FAULT. No retry counter.
//
// Ports
//   i_clk       system clock, rising edge (5 MHz nominal)
//   i_rst_n     asynchronous active-low reset
//   i_en        power request (level)
//   i_rdy_iref  reference ready (synchronous)
//   i_rdy_blk   consumer ready (synchronous)
//   o_pu_iref   reference power-up
//   o_cal_iref  reference calibration enable
//   o_pu_blk    consumer power-up
//   o_sys_rdy   sequence complete
//   o_fault     sticky fault flag
//   o_state     current state encoding (debug)
// ---------------------------------------------------------------------------
module iref_pwr_seq #(
    parameter int T_SETTLE_CYC = 5,
    parameter int IREF_TO_CYC  = 64,
    parameter int BLK_TO_CYC   = 64,
    parameter int CNT_W        = 8,
    parameter int MAX_RETRY    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_rdy_iref,
    input  logic       i_rdy_blk,
    output logic       o_pu_iref,
    output logic       o_cal_iref,
    output logic       o_pu_blk,
    output logic       o_sys_rdy,
    output logic       o_fault,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_SETTLE = 3'd1,
        S_CAL    = 3'd2,
        S_BLK    = 3'd3,
        S_ACTIVE = 3'd4,
        S_PWRDN  = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_timer;
    logic               r_pu_iref;
    logic               r_cal_iref;
    logic               r_pu_blk;
    logic               r_sys_rdy;
    logic               r_fault;

    state_t             w_nxt_state;
    logic [CNT_W-1:0]   w_nxt_timer;
    logic [CNT_W-1:0]   w_timer_dec;
    logic               w_timeout;
    state_t             w_to_state;

`ifdef IREF_PWR_SEQ_RETRY_EN
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0]   r_retry;
    logic [RTY_W-1:0]   w_nxt_retry;
    logic [RTY_W-1:0]   w_to_retry;

    // Timeout target: retry through PWRDN while budget remains.
    always_comb begin
        if (r_retry < RTY_W'(MAX_RETRY)) begin
            w_to_state = S_PWRDN;
            w_to_retry = r_retry + RTY_W'(1);
        end else begin
            w_to_state = S_FAULT;
            w_to_retry = r_retry;
        end
    end
`else
    assign w_to_state = S_FAULT;
`endif

    // Saturating decrement: the timer never wraps below zero.
    assign w_timer_dec = (r_timer != '0) ? r_timer - CNT_W'(1) : '0;
    assign w_timeout   = (r_timer == CNT_W'(1));

    // Next-state: EN=0 beats ready, ready beats timeout.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_timer = w_timer_dec;
`ifdef IREF_PWR_SEQ_RETRY_EN
        w_nxt_retry = r_retry;
`endif
        case (r_state)
            S_OFF: begin
                w_nxt_timer = '0;
                if (i_en) begin
                    w_nxt_state = S_SETTLE;
                    w_nxt_timer = CNT_W'(T_SETTLE_CYC);
                end
            end
            S_SETTLE: begin
                if (!i_en) begin
                    w_nxt_state = S_PWRDN;
                    w_nxt_timer = '0;
                end else if (w_timeout) begin
                    w_nxt_state = S_CAL;
                    w_nxt_timer = CNT_W'(IREF_TO_CYC);
                end
            end
            S_CAL: begin
                if (!i_en) begin
                    w_nxt_state = S_PWRDN;
                    w_nxt_timer = '0;
                end else if (i_rdy_iref) begin
                    w_nxt_state = S_BLK;
                    w_nxt_timer = CNT_W'(BLK_TO_CYC);
                end else if (w_timeout) begin
                    w_nxt_state = w_to_state;
                    w_nxt_timer = '0;
`ifdef IREF_PWR_SEQ_RETRY_EN
                    w_nxt_retry = w_to_retry;
`endif
                end
            end
            S_BLK: begin
                if (!i_en) begin
                    w_nxt_state = S_PWRDN;
                    w_nxt_timer = '0;
                end else if (i_rdy_blk) begin
                    w_nxt_state = S_ACTIVE;
                    w_nxt_timer = '0;
`ifdef IREF_PWR_SEQ_RETRY_EN
                    w_nxt_retry = '0;
`endif
                end else if (w_timeout) begin
                    w_nxt_state = w_to_state;
                    w_nxt_timer = '0;
`ifdef IREF_PWR_SEQ_RETRY_EN
                    w_nxt_retry = w_to_retry;
`endif
                end
            end
            S_ACTIVE: begin
                w_nxt_timer = '0;
                if (!i_en)
                    w_nxt_state = S_PWRDN;
                else if (!i_rdy_iref || !i_rdy_blk)
                    w_nxt_state = S_FAULT;
            end
            S_PWRDN: begin
                // Always passes through OFF, even if EN came back.
                w_nxt_state = S_OFF;
                w_nxt_timer = '0;
            end
            S_FAULT: begin
                w_nxt_timer = '0;
                if (!i_en)
                    w_nxt_state = S_OFF;
            end
            default: begin
                w_nxt_state = S_OFF;
                w_nxt_timer = '0;
            end
        endcase
`ifdef IREF_PWR_SEQ_RETRY_EN
        if (!i_en)
            w_nxt_retry = '0;
`endif
    end

    // State, timer and outputs. Outputs are decoded from the next state so
    // they are registered yet change on the same edge as the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_OFF;
            r_timer    <= '0;
            r_pu_iref  <= 1'b0;
            r_cal_iref <= 1'b0;
            r_pu_blk   <= 1'b0;
            r_sys_rdy  <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_timer    <= w_nxt_timer;
            r_pu_iref  <= (w_nxt_state == S_SETTLE) || (w_nxt_state == S_CAL) ||
                          (w_nxt_state == S_BLK)    || (w_nxt_state == S_ACTIVE) ||
                          (w_nxt_state == S_PWRDN);
            r_cal_iref <= (w_nxt_state == S_CAL);
            r_pu_blk   <= (w_nxt_state == S_BLK) || (w_nxt_state == S_ACTIVE);
            r_sys_rdy  <= (w_nxt_state == S_ACTIVE);
            r_fault    <= (w_nxt_state == S_FAULT);
        end
    end

`ifdef IREF_PWR_SEQ_RETRY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_retry <= '0;
        else
            r_retry <= w_nxt_retry;
    end
`endif

    assign o_pu_iref  = r_pu_iref;
    assign o_cal_iref = r_cal_iref;
    assign o_pu_blk   = r_pu_blk;
    assign o_sys_rdy  = r_sys_rdy;
    assign o_fault    = r_fault;
    assign o_state    = r_state;

endmodule

// File: tb/tb_iref_pwr_seq.sv
// ---------------------------------------------------------------------------
// tb_iref_pwr_seq
//   Directed stimulus; each step pushes the expected {state, outputs} for a
//   given cycle into a queue. A monitor on the falling edge pops entries due
//   at the current cycle and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_iref_pwr_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rdy_iref;
    logic       rdy_blk;
    logic       pu_iref, cal_iref, pu_blk, sys_rdy, fault;
    logic [2:0] state;

    localparam logic [2:0] OFF = 3'd0, SETTLE = 3'd1, CAL = 3'd2, BLK = 3'd3,
                           ACTIVE = 3'd4, PWRDN = 3'd5, FLT = 3'd6;

    iref_pwr_seq dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_rdy_iref (rdy_iref),
        .i_rdy_blk  (rdy_blk),
        .o_pu_iref  (pu_iref),
        .o_cal_iref (cal_iref),
        .o_pu_blk   (pu_blk),
        .o_sys_rdy  (sys_rdy),
        .o_fault    (fault),
        .o_state    (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tgt;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Expected output vector for a state: {state, fault, sys_rdy, pu_blk, cal, pu_iref}
    function automatic logic [7:0] exp_of(input logic [2:0] s);
        case (s)
            OFF:     return {s, 5'b00000};
            SETTLE:  return {s, 5'b00001};
            CAL:     return {s, 5'b00011};
            BLK:     return {s, 5'b00101};
            ACTIVE:  return {s, 5'b01101};
            PWRDN:   return {s, 5'b00001};
            FLT:     return {s, 5'b10000};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic chk(input logic [2:0] s, input string name);
        exp_t e;
        e.tgt  = cyc;
        e.exp  = exp_of(s);
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [7:0] obs;
        exp_t e;
        obs = {state, fault, sys_rdy, pu_blk, cal_iref, pu_iref};
        while (q.size() > 0 && q[0].tgt <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.tgt < cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                         e.name, e.tgt, cyc);
            end else if (obs !== e.exp) begin
                failures++;
                $display("FAIL %s @cyc %0d: got state=%0d f/rdy/blk/cal/pu=%b, want state=%0d f/rdy/blk/cal/pu=%b",
                         e.name, cyc, obs[7:5], obs[4:0], e.exp[7:5], e.exp[4:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; rdy_iref = 1'b0; rdy_blk = 1'b0;
        step(3);
        chk(OFF, "reset");
        rst_n = 1'b1;

        // ---- Nominal power-up (cycle 0 = EN assertion) ----
        en = 1'b1;
        step(1);  chk(SETTLE, "pu_iref_c1");
        step(4);  chk(SETTLE, "settle_c5");
        step(1);  chk(CAL,    "cal_c6");
        step(35); chk(CAL,    "cal_c41");
        rdy_iref = 1'b1;                    // 36 cycles after CAL_IREF
        step(1);  chk(BLK,    "blk_c42");
        step(9);  chk(BLK,    "blk_c51");
        rdy_blk = 1'b1;                     // 10 cycles after PU_BLK
        step(1);  chk(ACTIVE, "active_c52");
        step(3);  chk(ACTIVE, "active_hold");

        // ---- Power-down ordering ----
        en = 1'b0;
        step(1);  chk(PWRDN, "pwrdn_blk_first");
        step(1);  chk(OFF,   "pwrdn_iref_off");
        rdy_iref = 1'b0; rdy_blk = 1'b0;
        step(2);  chk(OFF,   "off_idle");

        // ---- RDY_IREF on the timer==1 cycle wins over timeout ----
        en = 1'b1;
        step(1);  chk(SETTLE, "sim_settle");
        step(5);  chk(CAL,    "sim_cal");
        step(63); chk(CAL,    "sim_cal_last");
        rdy_iref = 1'b1;
        step(1);  chk(BLK,    "rdy_beats_timeout");
        // EN=0 with RDY_BLK in the same cycle -> PWRDN
        rdy_blk = 1'b1; en = 1'b0;
        step(1);  chk(PWRDN, "en0_beats_rdy");
        step(1);  chk(OFF,   "en0_off");
        rdy_iref = 1'b0; rdy_blk = 1'b0;

`ifndef IREF_PWR_SEQ_RETRY_EN
        // ---- IREF timeout: FAULT exactly 64 cycles after CAL rise ----
        en = 1'b1;
        step(1);  chk(SETTLE, "to_settle");
        step(5);  chk(CAL,    "to_cal");
        step(63); chk(CAL,    "to_cal_63");
        step(1);  chk(FLT,    "iref_timeout");
        step(5);  chk(FLT,    "fault_sticky");
        en = 1'b0;
        step(1);  chk(OFF,    "fault_clear");

        // ---- BLK timeout ----
        en = 1'b1; rdy_iref = 1'b1;
        step(1);  chk(SETTLE, "bto_settle");
        step(5);  chk(CAL,    "bto_cal");
        step(1);  chk(BLK,    "bto_blk");
        step(63); chk(BLK,    "bto_blk_63");
        step(1);  chk(FLT,    "blk_timeout");
        en = 1'b0;
        step(1);  chk(OFF,    "bto_clear");
        rdy_iref = 1'b0;
`else
        // ---- Retry: RDY_BLK stuck low, three 64-cycle PU_BLK pulses ----
        en = 1'b1; rdy_iref = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);  chk(SETTLE, "rty_settle");
            step(5);  chk(CAL,    "rty_cal");
            step(1);  chk(BLK,    "rty_blk");
            step(63); chk(BLK,    "rty_blk_63");
            step(1);  chk((i < 2) ? PWRDN : FLT, "rty_timeout");
            if (i < 2) begin
                step(1); chk(OFF, "rty_off");
            end
        end
        en = 1'b0;
        step(1);  chk(OFF, "rty_clear");
        rdy_iref = 1'b0;
`endif

        // ---- Loss of ready in ACTIVE -> FAULT ----
        en = 1'b1; rdy_iref = 1'b1; rdy_blk = 1'b1;
        step(1);  chk(SETTLE, "lr_settle");
        step(5);  chk(CAL,    "lr_cal");
        step(1);  chk(BLK,    "lr_blk");
        step(1);  chk(ACTIVE, "lr_active");
        rdy_blk = 1'b0;
        step(1);  chk(FLT,    "loss_of_ready");
        en = 1'b0;
        step(1);  chk(OFF,    "lr_clear");

        // ---- One-cycle EN glitch in ACTIVE: full power-down and restart ----
        en = 1'b1; rdy_blk = 1'b1;
        step(8);  chk(ACTIVE, "gl_active");
        en = 1'b0;
        step(1);  chk(PWRDN,  "gl_pwrdn");
        en = 1'b1;
        step(1);  chk(OFF,    "gl_off");
        step(1);  chk(SETTLE, "gl_restart");

        // ---- Async reset in CAL ----
        step(5);  chk(CAL,    "ar_cal");
        step(1);  chk(BLK,    "ar_blk_ok");
        en = 1'b0;
        step(1);  chk(PWRDN,  "ar_pd");
        step(1);  chk(OFF,    "ar_off");
        rdy_iref = 1'b0; rdy_blk = 1'b0; en = 1'b1;
        step(1);  chk(SETTLE, "ar_settle");
        step(5);  chk(CAL,    "ar_cal2");
        step(2);
        rst_n = 1'b0;                       // mid-cycle, before the falling edge
        chk(OFF, "async_reset");
        #6 rst_n = 1'b1;                    // release before the next rising edge
        step(1);  chk(SETTLE, "reset_restart");
        en = 1'b0;
        step(1);  chk(PWRDN,  "end_pd");
        step(1);  chk(OFF,    "end_off");

        // Drain scoreboard with a bounded wait
        for (int k = 0; k < 10 && q.size() > 0; k++) step(1);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
